cam_pattern_gen: RTL and testbench
==================================

CAM_PATTERN_GEN -- requirements
Module: cam_pattern_gen

Interface
REQ-001 Parameter IMG_WIDTH, default 640, active pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 480, active lines per frame.
REQ-003 Parameter H_BLANK, default 2, href-low cycles after every line.
REQ-004 Parameter VSYNC_LEN, default 2, vsync-high cycles per frame.
REQ-005 Parameter V_BLANK, default 4, idle cycles between vsync fall and first href.
REQ-006 clk  in  1  pixel clock, all logic on the rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 enable  in  1  permits new frames to start.
REQ-009 start  in  1  one-cycle pulse that requests a single frame.
REQ-010 continuous  in  1  back-to-back frames while high.
REQ-011 pattern_sel  in  3  pattern code, sampled at frame start.
REQ-012 vsync  out  1  frame sync, DVP style, active high.
REQ-013 href  out  1  line valid.
REQ-014 pixel_out  out  16  RGB565 pixel, valid when href=1.
REQ-015 busy  out  1  high from frame start until the DONE cycle.
REQ-016 frame_done  out  1  one-cycle pulse at the end of a frame.
REQ-017 frame_cnt  out  8  completed frames, wraps 255->0.

Function
REQ-018 The FSM SHALL have the states IDLE, VSYNC, VBLANK, LINE, HBLANK and DONE.
REQ-019 IDLE->VSYNC when enable && (start || continuous); the pattern_sel latch SHALL be loaded on that transition.
REQ-020 VSYNC SHALL hold vsync=1 for exactly VSYNC_LEN cycles, then move to VBLANK.
REQ-021 VBLANK SHALL last V_BLANK cycles with vsync=0 and href=0, then move to LINE.
REQ-022 LINE SHALL hold href=1 for exactly IMG_WIDTH cycles, with x counting from 0 to IMG_WIDTH-1, then move to HBLANK.
REQ-023 HBLANK SHALL last H_BLANK cycles with href=0.
REQ-024 At the end of HBLANK, y SHALL increment and the FSM SHALL return to LINE; on the last line (y=IMG_HEIGHT-1) the FSM SHALL go to DONE instead.
REQ-025 DONE SHALL last 1 cycle with frame_done=1 and frame_cnt incremented.
REQ-026 From DONE, the next state SHALL be VSYNC if enable && continuous, otherwise IDLE.
REQ-027 Frame length SHALL be VSYNC_LEN+V_BLANK+IMG_HEIGHT*(IMG_WIDTH+H_BLANK)+1 cycles.
REQ-028 vsync, href and pixel_out SHALL all be registered and mutually cycle-aligned.
REQ-029 pixel_out SHALL be 16'h0000 whenever href=0.
REQ-030 Pattern codes (x,y = pixel coordinates):
- 0: x<IMG_WIDTH/2 ? 0000 : FFFF
- 1: y<IMG_HEIGHT/2 ? 0000 : FFFF
- 2: (x[3]^y[3]) ? FFFF : 0000
- 3: {x[7:3],x[7:2],x[7:3]}
- 4: A5A5
- 5-7: 0000
REQ-031 Deasserting enable mid-frame SHALL NOT truncate the frame; the generator SHALL finish it and then go IDLE.
REQ-032 start while busy SHALL be ignored, and pattern_sel changes mid-frame SHALL be ignored.

Reset
REQ-033 On rst_n=0 the FSM SHALL go to IDLE immediately and asynchronously, even mid-frame.
REQ-034 On reset, vsync, href, busy and frame_done SHALL be 0, pixel_out 16'h0000, frame_cnt 0, and all counters and the pattern latch 0.
REQ-035 After reset release, the first frame SHALL start only on a fresh start pulse or on continuous=1.

Configuration
REQ-036 With CAM_PATTERN_CHECKSUM_EN defined, the block SHALL add output frame_sum[15:0]: the modulo-2^16 sum of all href=1 pixels in the frame, cleared at VSYNC entry and valid from the DONE cycle until the next VSYNC.
REQ-037 Without CAM_PATTERN_CHECKSUM_EN, the frame_sum port and its adder SHALL be absent; all other behaviour is identical.

Structure
REQ-038 Package cam_pkg SHALL hold the FSM state enum, the pattern code constants (PAT_VEDGE, PAT_HEDGE, PAT_CHECK, PAT_RAMP, PAT_SOLID) and the RGB565 constants BLACK=0000 and WHITE=FFFF.
REQ-039 One sub-module, cam_pattern_rom, SHALL map (pattern, x, y) to a pixel combinationally; the parent SHALL register its output.

Verification (IMG_WIDTH=20, IMG_HEIGHT=5, H_BLANK=2, VSYNC_LEN=2, V_BLANK=4)
REQ-040 Pattern 0, start pulse -> per line href high for 20 cycles, pixels 0000 x10 then FFFF x10, 5 lines, frame_done 117 cycles after VSYNC entry, frame_cnt=1.
REQ-041 Pattern 4, continuous=1 for 3 frames -> every href=1 pixel is A5A5, the second vsync rises the cycle after the first frame_done, frame_cnt=3.
REQ-042 rst_n low during line 2 -> vsync, href and pixel_out are 0 within the same cycle; no frame_done; frame_cnt=0.
REQ-043 enable dropped during line 1 with continuous=1 -> the frame completes (5 lines), frame_done pulses once, then IDLE and busy=0.
REQ-044 pattern_sel changed from 2 to 4 mid-frame -> the current frame stays checkerboard and the next frame is A5A5.
REQ-045 With CAM_PATTERN_CHECKSUM_EN defined, pattern 0 -> frame_sum = (50*FFFF) mod 2^16 = FFCE at DONE.

Source files
------------

// File: rtl/cam_pattern_gen_pkg.sv
// Shared definitions for the camera test-pattern generator: FSM state
// encoding, pattern codes, RGB565 colour constants and coordinate width.
package cam_pkg;

    // Width of the internal x/y/phase counters.
    localparam int COORD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBLANK = 3'd2,
        ST_LINE   = 3'd3,
        ST_HBLANK = 3'd4,
        ST_DONE   = 3'd5
    } cam_state_e;

    localparam logic [2:0] PAT_VEDGE = 3'd0;
    localparam logic [2:0] PAT_HEDGE = 3'd1;
    localparam logic [2:0] PAT_CHECK = 3'd2;
    localparam logic [2:0] PAT_RAMP  = 3'd3;
    localparam logic [2:0] PAT_SOLID = 3'd4;

    localparam logic [15:0] BLACK       = 16'h0000;
    localparam logic [15:0] WHITE       = 16'hFFFF;
    localparam logic [15:0] SOLID_COLOR = 16'hA5A5;

    // Two-level pixel: white when the selector is set, black otherwise.
    function automatic logic [15:0] bw_pixel(input logic white);
        return white ? WHITE : BLACK;
    endfunction

endpackage

// File: rtl/cam_pattern_rom.sv
// Combinational pattern lookup: maps (pattern, x, y) to an RGB565 pixel.
// The parent registers the result so it lines up with href.
module cam_pattern_rom
    import cam_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic [2:0]         pattern,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [15:0]        pixel
);

    localparam logic [COORD_W-1:0] X_HALF = COORD_W'(IMG_WIDTH / 2);
    localparam logic [COORD_W-1:0] Y_HALF = COORD_W'(IMG_HEIGHT / 2);

    // Pattern decode; unused codes produce black.
    always_comb begin
        pixel = BLACK;
        case (pattern)
            PAT_VEDGE: pixel = bw_pixel(x >= X_HALF);
            PAT_HEDGE: pixel = bw_pixel(y >= Y_HALF);
            PAT_CHECK: pixel = bw_pixel(x[3] ^ y[3]);
            PAT_RAMP:  pixel = {x[7:3], x[7:2], x[7:3]};
            PAT_SOLID: pixel = SOLID_COLOR;
            default:   pixel = BLACK;
        endcase
    end

endmodule

// File: rtl/cam_pattern_gen.sv
// DVP-style camera test-pattern generator (vsync/href/pixel_out).
// Optional feature: define CAM_PATTERN_CHECKSUM_EN to add the frame_sum
// output, a modulo-2^16 sum of all active pixels of the last frame.
// Blanking parameters (VSYNC_LEN, V_BLANK, H_BLANK) are assumed >= 1.
module cam_pattern_gen
    import cam_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int H_BLANK    = 2,
    parameter int VSYNC_LEN  = 2,
    parameter int V_BLANK    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        start,
    input  logic        continuous,
    input  logic [2:0]  pattern_sel,
    output logic        vsync,
    output logic        href,
    output logic [15:0] pixel_out,
    output logic        busy,
    output logic        frame_done,
`ifdef CAM_PATTERN_CHECKSUM_EN
    output logic [15:0] frame_sum,
`endif
    output logic [7:0]  frame_cnt
);

    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(IMG_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(IMG_HEIGHT - 1);
    localparam logic [COORD_W-1:0] VS_LAST = COORD_W'(VSYNC_LEN - 1);
    localparam logic [COORD_W-1:0] VB_LAST = COORD_W'(V_BLANK - 1);
    localparam logic [COORD_W-1:0] HB_LAST = COORD_W'(H_BLANK - 1);

    cam_state_e         state_r;
    logic [COORD_W-1:0] cnt_r;
    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;
    logic [2:0]         pat_r;
    logic               vsync_r;
    logic               href_r;
    logic [15:0]        pixel_r;
    logic               busy_r;
    logic               done_r;
    logic [7:0]         fcnt_r;

    logic               start_frame_s;
    logic [COORD_W-1:0] rom_x_s;
    logic [COORD_W-1:0] rom_y_s;
    logic [15:0]        rom_pix_s;

    // A new frame may begin only from IDLE or straight out of DONE.
    always_comb begin
        start_frame_s = 1'b0;
        if (state_r == ST_IDLE) begin
            start_frame_s = enable && (start || continuous);
        end else if (state_r == ST_DONE) begin
            start_frame_s = enable && continuous;
        end else begin
            start_frame_s = 1'b0;
        end
    end

    // Coordinate of the pixel that will be on the output next cycle, so the
    // registered pixel lines up with the registered href.
    always_comb begin
        rom_x_s = {COORD_W{1'b0}};
        rom_y_s = y_r;
        if (state_r == ST_LINE) begin
            rom_x_s = x_r + 16'd1;
        end else begin
            rom_x_s = {COORD_W{1'b0}};
        end
        if (state_r == ST_HBLANK) begin
            rom_y_s = y_r + 16'd1;
        end else begin
            rom_y_s = y_r;
        end
    end

    cam_pattern_rom #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_rom (
        .pattern (pat_r),
        .x       (rom_x_s),
        .y       (rom_y_s),
        .pixel   (rom_pix_s)
    );

    // Frame sequencer with all video outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {COORD_W{1'b0}};
            x_r     <= {COORD_W{1'b0}};
            y_r     <= {COORD_W{1'b0}};
            pat_r   <= 3'd0;
            vsync_r <= 1'b0;
            href_r  <= 1'b0;
            pixel_r <= BLACK;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            fcnt_r  <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (start_frame_s) begin
                        state_r <= ST_VSYNC;
                        pat_r   <= pattern_sel;
                        cnt_r   <= {COORD_W{1'b0}};
                        x_r     <= {COORD_W{1'b0}};
                        y_r     <= {COORD_W{1'b0}};
                        vsync_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_VSYNC: begin
                    if (cnt_r == VS_LAST) begin
                        state_r <= ST_VBLANK;
                        cnt_r   <= {COORD_W{1'b0}};
                        vsync_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_VBLANK: begin
                    if (cnt_r == VB_LAST) begin
                        state_r <= ST_LINE;
                        x_r     <= {COORD_W{1'b0}};
                        href_r  <= 1'b1;
                        pixel_r <= rom_pix_s;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_LINE: begin
                    if (x_r == X_LAST) begin
                        state_r <= ST_HBLANK;
                        cnt_r   <= {COORD_W{1'b0}};
                        href_r  <= 1'b0;
                        pixel_r <= BLACK;
                    end else begin
                        x_r     <= x_r + 16'd1;
                        pixel_r <= rom_pix_s;
                    end
                end
                ST_HBLANK: begin
                    if (cnt_r != HB_LAST) begin
                        cnt_r <= cnt_r + 16'd1;
                    end else if (y_r == Y_LAST) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        fcnt_r  <= fcnt_r + 8'd1;
                    end else begin
                        state_r <= ST_LINE;
                        y_r     <= y_r + 16'd1;
                        x_r     <= {COORD_W{1'b0}};
                        href_r  <= 1'b1;
                        pixel_r <= rom_pix_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    vsync_r <= 1'b0;
                    href_r  <= 1'b0;
                    pixel_r <= BLACK;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CAM_PATTERN_CHECKSUM_EN
    logic [15:0] sum_r;

    // Running sum of every active pixel; restarts as the next frame begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r <= 16'h0000;
        end else if (start_frame_s) begin
            sum_r <= 16'h0000;
        end else if (href_r) begin
            sum_r <= sum_r + pixel_r;
        end
    end

    assign frame_sum = sum_r;
`else
    // Default build: no checksum port and no accumulator.
`endif

    assign vsync      = vsync_r;
    assign href       = href_r;
    assign pixel_out  = pixel_r;
    assign busy       = busy_r;
    assign frame_done = done_r;
    assign frame_cnt  = fcnt_r;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Directed, scoreboard-based bench for cam_pattern_gen on a 20x5 frame.
// Expected pixels (and frame sums) are queued when a frame is requested and
// consumed by a negedge monitor while href is high.
module tb_cam_pattern_gen;

    localparam int W         = 20;
    localparam int H         = 5;
    localparam int HB        = 2;
    localparam int VS        = 2;
    localparam int VB        = 4;
    localparam int FRAME_LEN = 117;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [2:0]  pattern_sel = 3'd0;
    logic        vsync;
    logic        href;
    logic [15:0] pixel_out;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frame_cnt;
`ifdef CAM_PATTERN_CHECKSUM_EN
    logic [15:0] frame_sum;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] sb[$];
    logic [15:0] sum_q[$];

    logic mon_en = 1'b0;
    logic vsync_q = 1'b0;
    logic href_q = 1'b0;
    int   cyc = 0;
    int   vs_rise = 0;
    int   run_len = 0;
    int   lines = 0;
    int   done_cnt = 0;

    cam_pattern_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .H_BLANK    (HB),
        .VSYNC_LEN  (VS),
        .V_BLANK    (VB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .start       (start),
        .continuous  (continuous),
        .pattern_sel (pattern_sel),
        .vsync       (vsync),
        .href        (href),
        .pixel_out   (pixel_out),
        .busy        (busy),
        .frame_done  (frame_done),
`ifdef CAM_PATTERN_CHECKSUM_EN
        .frame_sum   (frame_sum),
`endif
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_pix(input int p, input int x, input int y);
        int r;
        int g;
        case (p)
            0: return (x < W / 2) ? 16'h0000 : 16'hFFFF;
            1: return (y < H / 2) ? 16'h0000 : 16'hFFFF;
            2: return ((((x / 8) + (y / 8)) % 2) == 1) ? 16'hFFFF : 16'h0000;
            3: begin
                r = (x / 8) % 32;
                g = (x / 4) % 64;
                return 16'(r * 2048 + g * 32 + r);
            end
            4: return 16'hA5A5;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic push_frame(input int p);
        int s = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                sb.push_back(exp_pix(p, x, y));
                s += int'(exp_pix(p, x, y));
            end
        end
        sum_q.push_back(16'(s));
    endtask

    // Per-cycle monitor: pixel scoreboard, blanking, line and frame timing.
    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (vsync && !vsync_q) vs_rise = cyc;
            if (href) begin
                if (sb.size() > 0) check("pixel", {16'd0, pixel_out}, {16'd0, sb.pop_front()});
                else check("href_unexpected", {31'd0, href}, 32'd0);
                run_len++;
            end else begin
                check("pixel_blank", {16'd0, pixel_out}, 32'd0);
                if (href_q) begin
                    check("line_len", run_len, W);
                    lines++;
                end
                run_len = 0;
            end
            if (frame_done) begin
                done_cnt++;
                check("frame_len", cyc - vs_rise + 1, FRAME_LEN);
                check("lines_per_frame", lines, H);
                lines = 0;
`ifdef CAM_PATTERN_CHECKSUM_EN
                if (sum_q.size() > 0) check("frame_sum", {16'd0, frame_sum}, {16'd0, sum_q.pop_front()});
`endif
            end
            vsync_q = vsync;
            href_q  = href;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_vsync", {31'd0, vsync}, 32'd0);
        check("rst_href", {31'd0, href}, 32'd0);
        check("rst_pixel", {16'd0, pixel_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
`ifdef CAM_PATTERN_CHECKSUM_EN
        check("rst_frame_sum", {16'd0, frame_sum}, 32'd0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        sum_q.delete();
        vsync_q = 1'b0;
        href_q = 1'b0;
        run_len = 0;
        lines = 0;
        mon_en = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 400);
        check({tag, "_done_seen"}, {31'd0, frame_done}, 32'd1);
    endtask

    task automatic wait_href_rise(input int count, input string tag);
        int n = 0;
        int seen = 0;
        logic prev = href;
        while (seen < count && n < 400) begin
            @(negedge clk);
            n++;
            if (href && !prev) seen++;
            prev = href;
        end
        check({tag, "_href_rises"}, seen, count);
    endtask

    initial begin
        int d0;

        // Pattern 0 single frame; mid-frame start and pattern change ignored.
        do_reset();
        repeat (5) @(negedge clk);
        check("a_idle_no_start", {31'd0, busy}, 32'd0);
        pattern_sel = 3'd0;
        push_frame(0);
        d0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("a_busy", {31'd0, busy}, 32'd1);
        check("a_vsync", {31'd0, vsync}, 32'd1);
        wait_href_rise(2, "a");
        pattern_sel = 3'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("a");
        check("a_frame_cnt", {24'd0, frame_cnt}, 32'd1);
`ifdef CAM_PATTERN_CHECKSUM_EN
        check("a_sum_ffce", {16'd0, frame_sum}, 32'h0000FFCE);
`endif
        repeat (150) @(negedge clk);
        check("a_busy_after", {31'd0, busy}, 32'd0);
        check("a_done_count", done_cnt - d0, 1);
        check("a_sb_drained", sb.size(), 0);

        // Pattern 4, three continuous frames back to back.
        do_reset();
        pattern_sel = 3'd4;
        repeat (3) push_frame(4);
        continuous = 1'b1;
        wait_done("b1");
        @(negedge clk);
        check("b_vsync_after_done1", {31'd0, vsync}, 32'd1);
        wait_done("b2");
        @(negedge clk);
        check("b_vsync_after_done2", {31'd0, vsync}, 32'd1);
        continuous = 1'b0;
        wait_done("b3");
        check("b_frame_cnt", {24'd0, frame_cnt}, 32'd3);
        repeat (150) @(negedge clk);
        check("b_busy_after", {31'd0, busy}, 32'd0);
        check("b_sb_drained", sb.size(), 0);

        // Asynchronous reset in the middle of line 2.
        do_reset();
        pattern_sel = 3'd1;
        push_frame(1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_href_rise(3, "c");
        repeat (4) @(negedge clk);
        d0 = done_cnt;
        do_reset();
        repeat (200) @(negedge clk);
        check("c_no_done", done_cnt - d0, 0);
        check("c_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check("c_busy", {31'd0, busy}, 32'd0);

        // Enable dropped during line 1 in continuous mode.
        do_reset();
        pattern_sel = 3'd3;
        push_frame(3);
        d0 = done_cnt;
        continuous = 1'b1;
        wait_href_rise(2, "d");
        enable = 1'b0;
        wait_done("d");
        repeat (150) @(negedge clk);
        check("d_done_once", done_cnt - d0, 1);
        check("d_busy", {31'd0, busy}, 32'd0);
        check("d_frame_cnt", {24'd0, frame_cnt}, 32'd1);
        check("d_sb_drained", sb.size(), 0);
        continuous = 1'b0;
        enable = 1'b1;

        // Pattern switch 2 -> 4 mid-frame takes effect on the next frame.
        do_reset();
        pattern_sel = 3'd2;
        push_frame(2);
        push_frame(4);
        continuous = 1'b1;
        wait_href_rise(2, "e");
        pattern_sel = 3'd4;
        wait_done("e1");
        @(negedge clk);
        continuous = 1'b0;
        wait_done("e2");
        repeat (50) @(negedge clk);
        check("e_frame_cnt", {24'd0, frame_cnt}, 32'd2);
        check("e_sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
